// File: rtl/alu_pkg.sv
// Shared opcode encodings and widths for the registered ALU.
package alu_pkg;

  localparam int unsigned ALU_SEL_W = 3;

  localparam logic [ALU_SEL_W-1:0] ALU_ADD  = 3'b000;
  localparam logic [ALU_SEL_W-1:0] ALU_SUB  = 3'b001;
  localparam logic [ALU_SEL_W-1:0] ALU_MUL  = 3'b010;
  localparam logic [ALU_SEL_W-1:0] ALU_AND  = 3'b011;
  localparam logic [ALU_SEL_W-1:0] ALU_OR   = 3'b100;
  localparam logic [ALU_SEL_W-1:0] ALU_XOR  = 3'b101;
  localparam logic [ALU_SEL_W-1:0] ALU_SLL  = 3'b110;
  localparam logic [ALU_SEL_W-1:0] ALU_SLTU = 3'b111;

endpackage

// File: rtl/alu_if.sv
// Operand/result bundle between an ALU requester and the ALU datapath.
interface alu_if #(
  parameter int unsigned n = 32
) ();
  import alu_pkg::*;

  logic [n-1:0]         a;
  logic [n-1:0]         b;
  logic [ALU_SEL_W-1:0] sel;
  logic [n-1:0]         result;
  logic                 carry;

  modport master (output a, b, sel, input result, carry);
  modport slave (input a, b, sel, output result, carry);

endinterface

// File: rtl/alu_core.sv
// Combinational ALU datapath: operands and opcode in, result and carry/flag out.
module alu_core
  import alu_pkg::*;
#(
  parameter int unsigned n = 32
) (
  alu_if.slave bus
);

  localparam int unsigned ShW = $clog2(n);

  logic [n:0]     sum;
  logic [n-1:0]   diff;
  logic           borrow;
  logic [2*n-1:0] prod;
  logic [ShW-1:0] shamt;
  logic [n:0]     shl;
  logic [n-1:0]   res;
  logic           cry;

  assign sum    = {1'b0, bus.a} + {1'b0, bus.b};
  assign diff   = bus.a - bus.b;
  assign borrow = bus.a < bus.b;
  assign prod   = {{n{1'b0}}, bus.a} * {{n{1'b0}}, bus.b};
  assign shamt  = bus.b[ShW-1:0];
  // Bit n of the widened shift is the last bit pushed out of A; zero for a zero shift.
  assign shl    = {1'b0, bus.a} << shamt;

  always_comb begin
    res = '0;
    cry = 1'b0;
    case (bus.sel)
      ALU_ADD: begin
        res = sum[n-1:0];
        cry = sum[n];
      end
      ALU_SUB: begin
        res = diff;
        cry = borrow;
      end
      ALU_MUL: begin
        res = prod[n-1:0];
        cry = |prod[2*n-1:n];
      end
      ALU_AND: res = bus.a & bus.b;
      ALU_OR:  res = bus.a | bus.b;
      ALU_XOR: res = bus.a ^ bus.b;
      ALU_SLL: begin
        res = shl[n-1:0];
        cry = shl[n];
      end
      ALU_SLTU: res = {{(n-1){1'b0}}, borrow};
      default: begin
        res = '0;
        cry = 1'b0;
      end
    endcase
  end

  assign bus.result = res;
  assign bus.carry  = cry;

endmodule

// File: rtl/alu.sv
// Registered N-bit ALU: one cycle from operand sampling to visible result and flag.
module alu
  import alu_pkg::*;
#(
  parameter int unsigned n = 32
) (
  output logic [n-1:0]         ALU_out,
  output logic                 Carry_out,
  input  logic [n-1:0]         A,
  input  logic [n-1:0]         B,
  input  logic [ALU_SEL_W-1:0] ALU_sel,
  input  logic                 clk,
  input  logic                 rst_n
);

  alu_if #(.n(n)) core_bus ();

  assign core_bus.a   = A;
  assign core_bus.b   = B;
  assign core_bus.sel = ALU_sel;

  alu_core #(.n(n)) u_core (
    .bus (core_bus.slave)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ALU_out   <= '0;
      Carry_out <= 1'b0;
    end else begin
      ALU_out   <= core_bus.result;
      Carry_out <= core_bus.carry;
    end
  end

endmodule

// File: tb/tb_alu.sv
// Self-checking bench for alu: directed corner cases, async reset, random pipelined ops.
module tb_alu;
  import alu_pkg::*;

  localparam int unsigned N = 32;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   checks = 0;
  int   failures = 0;

  alu_if #(.n(N)) bus ();

  alu #(.n(N)) dut (
    .ALU_out   (bus.result),
    .Carry_out (bus.carry),
    .A         (bus.a),
    .B         (bus.b),
    .ALU_sel   (bus.sel),
    .clk       (clk),
    .rst_n     (rst_n)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [N-1:0] got, input logic [N-1:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  // Reference: plain 64-bit arithmetic on the operation definitions.
  function automatic void ref_model(input logic [2:0] sel, input logic [N-1:0] a,
                                    input logic [N-1:0] b, output logic [N-1:0] r,
                                    output logic c);
    longint unsigned la, lb, p, sh;
    la = 64'(a);
    lb = 64'(b);
    r  = '0;
    c  = 1'b0;
    case (sel)
      ALU_ADD: begin
        p = la + lb;
        r = p[N-1:0];
        c = p[N];
      end
      ALU_SUB: begin
        p = (la - lb) & ((64'd1 << N) - 1);
        r = p[N-1:0];
        c = (la < lb);
      end
      ALU_MUL: begin
        p = la * lb;
        r = p[N-1:0];
        c = ((p >> N) != 0);
      end
      ALU_AND: r = a & b;
      ALU_OR:  r = a | b;
      ALU_XOR: r = a ^ b;
      ALU_SLL: begin
        sh = lb % N;
        p  = la << sh;
        r  = p[N-1:0];
        c  = (sh != 0) && p[N];
      end
      default: r = (la < lb) ? 1 : 0;
    endcase
  endfunction

  task automatic run_op(input string tag, input logic [2:0] sel, input logic [N-1:0] a,
                        input logic [N-1:0] b, input logic [N-1:0] er, input logic ec);
    @(negedge clk);
    bus.a   = a;
    bus.b   = b;
    bus.sel = sel;
    @(posedge clk);
    #1;
    check_eq({tag, ".r"}, bus.result, er);
    check_eq({tag, ".c"}, N'(bus.carry), N'(ec));
  endtask

  logic [N-1:0] exp_r;
  logic         exp_c;
  logic [N-1:0] ra, rb;
  logic [2:0]   rsel;

  initial begin
    bus.a   = '0;
    bus.b   = '0;
    bus.sel = ALU_ADD;

    // Reset state, then release mid-cycle: outputs hold 0 until the next edge.
    #12;
    check_eq("rst.r", bus.result, '0);
    check_eq("rst.c", N'(bus.carry), '0);
    bus.a = 32'h5;
    bus.b = 32'h3;
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check_eq("rel.r", bus.result, '0);

    run_op("add0", ALU_ADD, 32'h0C, 32'h04, 32'h10, 1'b0);
    run_op("add1", ALU_ADD, 32'h0A, 32'h02, 32'h0C, 1'b0);
    run_op("add2", ALU_ADD, 32'hF6, 32'h0A, 32'h100, 1'b0);
    run_op("addw", ALU_ADD, 32'hFFFFFFFF, 32'h1, 32'h0, 1'b1);
    run_op("sub0", ALU_SUB, 32'h0A, 32'h02, 32'h08, 1'b0);
    run_op("subq", ALU_SUB, 32'h1234, 32'h1234, 32'h0, 1'b0);
    run_op("mul0", ALU_MUL, 32'h0A, 32'h02, 32'h14, 1'b0);
    run_op("mulo", ALU_MUL, 32'h10000, 32'h10000, 32'h0, 1'b1);
    run_op("and",  ALU_AND, 32'h0A, 32'h02, 32'h02, 1'b0);
    run_op("or",   ALU_OR,  32'h0A, 32'h02, 32'h0A, 1'b0);
    run_op("xor",  ALU_XOR, 32'h0A, 32'h02, 32'h08, 1'b0);
    run_op("sll0", ALU_SLL, 32'h0A, 32'h02, 32'h28, 1'b0);
    run_op("sllz", ALU_SLL, 32'h80000001, 32'h20, 32'h80000001, 1'b0);
    run_op("sllm", ALU_SLL, 32'h80000001, 32'h21, 32'h2, 1'b1);
    run_op("sllt", ALU_SLL, 32'h3, 32'h1F, 32'h80000000, 1'b1);
    run_op("slt0", ALU_SLTU, 32'h0A, 32'h02, 32'h0, 1'b0);
    run_op("slt1", ALU_SLTU, 32'h0F, 32'h05, 32'h0, 1'b0);
    run_op("slt2", ALU_SLTU, 32'h05, 32'h0F, 32'h1, 1'b0);
    run_op("subb", ALU_SUB, 32'h02, 32'h0A, 32'hFFFFFFF8, 1'b1);

    // Mid-cycle async reset with nonzero outputs, held across an edge.
    #2;
    rst_n = 1'b0;
    #1;
    check_eq("arst.r", bus.result, '0);
    check_eq("arst.c", N'(bus.carry), '0);
    @(posedge clk);
    #1;
    check_eq("hold.r", bus.result, '0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check_eq("rel2.r", bus.result, '0);
    check_eq("rel2.c", N'(bus.carry), '0);
    @(posedge clk);
    #1;
    check_eq("post.r", bus.result, 32'hFFFFFFF8);
    check_eq("post.c", N'(bus.carry), 1);

    // Back-to-back random ops; each result must appear exactly one edge later.
    for (int i = 0; i <= 1000; i++) begin
      @(negedge clk);
      if (i > 0) begin
        check_eq("rnd.r", bus.result, exp_r);
        check_eq("rnd.c", N'(bus.carry), N'(exp_c));
      end
      if (i < 1000) begin
        rsel = 3'($urandom_range(0, 7));
        ra   = ($urandom_range(0, 7) == 0) ? 32'hFFFFFFFF : 32'($urandom);
        case ($urandom_range(0, 5))
          0:       rb = ra;
          1:       rb = 32'($urandom_range(0, 40));
          2:       rb = 32'($urandom_range(0, 16'hFFFF));
          default: rb = 32'($urandom);
        endcase
        if (rsel == ALU_MUL && $urandom_range(0, 1) == 1) begin
          ra = ra & 32'h0000FFFF;
          rb = rb & 32'h0000FFFF;
        end
        bus.a   = ra;
        bus.b   = rb;
        bus.sel = rsel;
        ref_model(rsel, ra, rb, exp_r, exp_c);
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
